collect_buffer: RTL and testbench
=================================

Name: collect_buffer

Overview:
- Serial-in, parallel-out collector. Accepts one DATA_WIDTH element per cycle from a systolic-array column output and assembles BUFFER_SIZE elements into one wide word for write-back to memory.
- Counterpart of the parallel-load / serial-drain input buffers: element 0 is the first one accepted and lands in the MSB slice, matching the input buffers' drain order.
- Sits between the PE array output edge and the accelerator write-back path.

Parameters:
- DATA_WIDTH, 16, width of one element.
- BUFFER_SIZE, 16, elements per output word; legal range 2..63.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- push  input  1  element valid this cycle.
- push_data  input  DATA_WIDTH  element value.
- in_ready  output  1  collector can accept push this cycle.
- flush  input  1  close a partial word; unfilled slices are zero.
- out_valid  output  1  buffer_output holds a complete word.
- out_ready  input  1  consumer accepts buffer_output.
- buffer_output  output  BUFFER_SIZE*DATA_WIDTH  assembled word.
- count  output  6  elements held (0..BUFFER_SIZE).
- overflow  output  1  sticky push-while-not-ready flag (see Optional Feature).

Behaviour:
- Reset (async, rst=1): state COLLECT, all slices 0, count=0, out_valid=0, overflow=0. in_ready is 1 once reset is released. Reset mid-word discards the partial data.
- Slot mapping: element i (0-based accept order) sits in bits [DATA_WIDTH*(BUFFER_SIZE-i)-1 -: DATA_WIDTH].
- States: COLLECT, HOLD.
- COLLECT:
  - in_ready=1, out_valid=0.
  - push=1: write push_data to slot count; count+1 at the next edge.
  - If the accepted push makes count==BUFFER_SIZE: next state HOLD.
  - flush=1 with count>0, or together with a push: the push (if any) is written first, then next state HOLD. Remaining slots stay 0.
  - flush=1 with count==0 and no push: ignored.
- HOLD:
  - in_ready=0, out_valid=1. buffer_output and count are stable.
  - out_valid && out_ready: at the edge, clear all slots to 0, count=0, next state COLLECT. in_ready rises the following cycle; no same-cycle bypass.
  - push in HOLD: data dropped, state unchanged.
  - flush in HOLD: ignored.
- Latency: the final push to out_valid=1 is 1 cycle. The minimum word period is BUFFER_SIZE+1 cycles.
- buffer_output is driven directly from the slot registers; slots are always defined, with 0 for unfilled slots.

Optional Feature:
- Macro: COLLECT_OVERFLOW_FLAG_EN.
- Defined: overflow sets on any cycle with push=1 && in_ready=0. It stays set until rst.
- Not defined: overflow is tied 0, and drops in HOLD are silent.

Test Plan:
- Reset then push 0x0001..0x0010 on 16 consecutive cycles:
  - out_valid=1 one cycle after the last push.
  - buffer_output[255:240]=0x0001, [15:0]=0x0010, count=16.
- Full word held with out_ready=0 for 5 cycles:
  - buffer_output stable, in_ready=0.
  - Then out_ready=1 for 1 cycle: next cycle out_valid=0, count=0, buffer_output=0, in_ready=1.
- Push 0xAAAA, 0xBBBB, 0xCCCC, with flush on the same cycle as 0xCCCC:
  - out_valid=1, count=3, [255:208]=AAAA_BBBB_CCCC, all lower bits 0.
- Flush with count=0: no state change, out_valid stays 0.
- Push 0x1234 during HOLD:
  - Word unchanged.
  - With COLLECT_OVERFLOW_FLAG_EN, overflow=1 and it stays 1 after the drain; without the macro, overflow=0.
- Assert rst asynchronously mid-clock after 7 pushes:
  - count=0 and out_valid=0 immediately, without waiting for a clock edge.
  - A following 16-push word assembles correctly.

Source files
------------

// File: rtl/collect_buffer.sv
// rtl/collect_buffer.sv - serial-in, parallel-out element collector (element 0 in MSB slice).
// Optional sticky drop flag: define COLLECT_OVERFLOW_FLAG_EN.
module collect_buffer #(
   parameter int DATA_WIDTH  = 16,
   parameter int BUFFER_SIZE = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              push,
   input  logic [DATA_WIDTH-1:0]             push_data,
   output logic                              in_ready,
   input  logic                              flush,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [BUFFER_SIZE*DATA_WIDTH-1:0] buffer_output,
   output logic [5:0]                        count,
   output logic                              overflow
);

   localparam int WORD_WIDTH = BUFFER_SIZE * DATA_WIDTH;

   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   state_t                state;
   logic [WORD_WIDTH-1:0] slots;
   logic                  close_word;

   // A word closes when this push fills the last slot, or on a flush that leaves at least one element.
   assign close_word = (push && (count == 6'(BUFFER_SIZE - 1))) ||
                       (flush && (push || (count != 6'd0)));

   assign in_ready      = (state == COLLECT);
   assign out_valid     = (state == HOLD);
   assign buffer_output = slots;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= COLLECT;
         slots <= '0;
         count <= 6'd0;
      end else begin
         case (state)
            COLLECT: begin
               if (push) begin
                  for (int i = 0; i < BUFFER_SIZE; i++) begin
                     if (count == 6'(i)) begin
                        slots[DATA_WIDTH*(BUFFER_SIZE-i)-1 -: DATA_WIDTH] <= push_data;
                     end
                  end
                  count <= count + 6'd1;
               end
               if (close_word) begin
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  slots <= '0;
                  count <= 6'd0;
                  state <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

`ifdef COLLECT_OVERFLOW_FLAG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (push && !in_ready) begin
         overflow <= 1'b1;
      end
   end
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_collect_buffer.sv
// tb/tb_collect_buffer.sv - directed table-driven bench for collect_buffer.
module tb_collect_buffer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         push = 1'b0;
   logic [15:0]  push_data = '0;
   logic         in_ready;
   logic         flush = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [255:0] buffer_output;
   logic [5:0]   count;
   logic         overflow;

   int checks = 0;
   int errors = 0;

`ifdef COLLECT_OVERFLOW_FLAG_EN
   localparam logic EXP_OVF = 1'b1;
`else
   localparam logic EXP_OVF = 1'b0;
`endif

   collect_buffer #(.DATA_WIDTH(16), .BUFFER_SIZE(16)) dut (
      .clk(clk), .rst(rst), .push(push), .push_data(push_data), .in_ready(in_ready),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .buffer_output(buffer_output), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         push;
      logic [15:0]  data;
      logic         flush;
      logic         ready;
      logic         exp_valid;
      logic         exp_in_ready;
      logic [5:0]   exp_count;
      logic         check_word;
      logic [255:0] exp_word;
   } vec_t;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] base, output logic [255:0] word);
      word = '0;
      for (int i = 0; i < 16; i++) begin
         push = 1'b1;
         push_data = base + 16'(i);
         word[16*(16-i)-1 -: 16] = base + 16'(i);
         tick();
         chk($sformatf("count_push%0d", i), 256'(count), 256'(i + 1));
         chk($sformatf("valid_push%0d", i), 256'(out_valid), 256'(i == 15));
      end
      push = 1'b0;
   endtask

   vec_t         vecs[10];
   logic [255:0] word;
   logic [255:0] held;

   initial begin
      vecs[0] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 256'd0};
      vecs[1] = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 256'd0};
      vecs[2] = '{1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 256'd0};
      vecs[3] = '{1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b1, 1'b0, 6'd3, 1'b1,
                  {48'hAAAA_BBBB_CCCC, 208'd0}};
      vecs[4] = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 6'd3, 1'b1,
                  {48'hAAAA_BBBB_CCCC, 208'd0}};
      vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 6'd3, 1'b1,
                  {48'hAAAA_BBBB_CCCC, 208'd0}};
      vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b1, 256'd0};
      vecs[7] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 256'd0};
      vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 1'b1, {16'h5555, 240'd0}};
      vecs[9] = '{1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b1, 256'd0};

      #2;
      chk("rst_count", 256'(count), 256'd0);
      chk("rst_valid", 256'(out_valid), 256'd0);
      chk("rst_word", buffer_output, 256'd0);
      chk("rst_ovf", 256'(overflow), 256'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("rst_in_ready", 256'(in_ready), 256'd1);

      // Full word of 0x0001..0x0010
      push_word(16'h0001, word);
      chk("full_word", buffer_output, word);
      chk("full_msb", 256'(buffer_output[255:240]), 256'h0001);
      chk("full_lsb", 256'(buffer_output[15:0]), 256'h0010);
      held = buffer_output;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("hold_word%0d", i), buffer_output, held);
         chk($sformatf("hold_in_ready%0d", i), 256'(in_ready), 256'd0);
      end

      push = 1'b1;
      push_data = 16'h1234;
      tick();
      push = 1'b0;
      chk("drop_word", buffer_output, held);
      chk("drop_count", 256'(count), 256'd16);
      chk("drop_ovf", 256'(overflow), 256'(EXP_OVF));

      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("drain_valid", 256'(out_valid), 256'd0);
      chk("drain_count", 256'(count), 256'd0);
      chk("drain_word", buffer_output, 256'd0);
      chk("drain_in_ready", 256'(in_ready), 256'd1);
      chk("drain_ovf", 256'(overflow), 256'(EXP_OVF));

      for (int v = 0; v < 10; v++) begin
         push = vecs[v].push;
         push_data = vecs[v].data;
         flush = vecs[v].flush;
         out_ready = vecs[v].ready;
         tick();
         chk($sformatf("v%0d_valid", v), 256'(out_valid), 256'(vecs[v].exp_valid));
         chk($sformatf("v%0d_in_ready", v), 256'(in_ready), 256'(vecs[v].exp_in_ready));
         chk($sformatf("v%0d_count", v), 256'(count), 256'(vecs[v].exp_count));
         if (vecs[v].check_word) begin
            chk($sformatf("v%0d_word", v), buffer_output, vecs[v].exp_word);
         end
      end
      push = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;

      // Asynchronous reset in the middle of a partial word
      for (int i = 0; i < 7; i++) begin
         push = 1'b1;
         push_data = 16'h0F00 + 16'(i);
         tick();
      end
      push = 1'b0;
      chk("pre_rst_count", 256'(count), 256'd7);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_count", 256'(count), 256'd0);
      chk("async_rst_valid", 256'(out_valid), 256'd0);
      chk("async_rst_word", buffer_output, 256'd0);
      chk("async_rst_ovf", 256'(overflow), 256'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      push_word(16'hC000, word);
      chk("post_rst_word", buffer_output, word);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
